fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the execution stage: it generates sequential fetch addresses from a local PC, issues requests to instruction memory, buffers returned words with their PCs, and presents them as `inst_v_i`/`pc_i`/`inst_i`. It consumes the execution stage's redirect (`pc_v_x`/`pc_x`) to flush wrong-path work, discarding in-flight stale responses. It sits between the instruction memory port and the execution stage.

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the execution stage.
// Generates sequential word-aligned fetch addresses from a local PC, issues
// them to instruction memory under a credit limit, buffers returned words
// with their PCs and presents them in order. A redirect from execution
// flushes buffered work and discards responses still in flight.
//
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
// arrives while the buffer is empty (and is not being discarded) is
// presented in the same cycle.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   imem_req_v/_addr    fetch request valid / word-aligned address
//   imem_req_rdy        memory accepts the request
//   imem_rsp_v/_data    in-order response valid / instruction word
//   pc_v_x, pc_x        redirect from execution and its target
//   inst_rdy            downstream accepts the presented instruction
//   inst_v_i/pc_i/inst_i  presented instruction valid / PC / word
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_v,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_rdy,
    input  logic        imem_rsp_v,
    input  logic [31:0] imem_rsp_data,
    input  logic        pc_v_x,
    input  logic [31:0] pc_x,
    input  logic        inst_rdy,
    output logic        inst_v_i,
    output logic [31:0] pc_i,
    output logic [31:0] inst_i
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Wide enough to hold occ + outst without overflow.
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t           buf_q [BUF_DEPTH];
    logic [31:0]      tag_q [BUF_DEPTH];
    logic [PTR_W-1:0] buf_rd, buf_wr, tag_rd, tag_wr;
    logic [CNT_W-1:0] occ, outst, drop;
    logic [31:0]      fetch_pc;

    logic             fifo_empty, rsp_take, rsp_keep, byp;
    logic             inst_v, pop, pop_fifo, push, accept, req_v;
    logic [CNT_W-1:0] credit;
    entry_t           head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, credit and presentation decode.
    always_comb begin
        fifo_empty = (occ == '0);
        rsp_take   = imem_rsp_v && (outst != '0);
        rsp_keep   = rsp_take && !pc_v_x && (drop == '0);
`ifdef FETCH_BYPASS_EN
        byp        = fifo_empty && rsp_keep;
`else
        byp        = 1'b0;
`endif
        head = buf_q[buf_rd];
        if (fifo_empty) begin
            head = {tag_q[tag_rd], imem_rsp_data};
        end
        inst_v   = !pc_v_x && (!fifo_empty || byp);
        pop      = inst_v && inst_rdy;
        pop_fifo = pop && !fifo_empty;
        // A bypassed word that is consumed immediately never enters the FIFO.
        push     = rsp_keep && !(byp && pop);
        credit   = occ + outst - CNT_W'(pop);
        req_v    = !reset && !pc_v_x && (credit < CNT_W'(BUF_DEPTH));
        accept   = req_v && imem_req_rdy;
    end

    assign imem_req_v    = req_v;
    assign imem_req_addr = fetch_pc;
    assign inst_v_i      = inst_v;
    assign pc_i          = inst_v ? head.pc   : '0;
    assign inst_i        = inst_v ? head.inst : '0;

    // Control state: PC, pointers and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            buf_rd   <= '0;
            buf_wr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            occ      <= '0;
            outst    <= '0;
            drop     <= '0;
        end else if (pc_v_x) begin
            // Everything still in flight is wrong-path; a response landing
            // this cycle is discarded directly.
            fetch_pc <= pc_x & 32'hFFFF_FFFC;
            buf_rd   <= buf_wr;
            tag_rd   <= tag_wr;
            occ      <= '0;
            outst    <= outst - CNT_W'(rsp_take);
            drop     <= outst - CNT_W'(rsp_take);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_wr   <= ptr_inc(tag_wr);
            end
            if (rsp_take) begin
                if (drop != '0) begin
                    drop <= drop - CNT_W'(1);
                end else begin
                    tag_rd <= ptr_inc(tag_rd);
                end
            end
            outst <= outst + CNT_W'(accept) - CNT_W'(rsp_take);
            if (push) begin
                buf_wr <= ptr_inc(buf_wr);
            end
            if (pop_fifo) begin
                buf_rd <= ptr_inc(buf_rd);
            end
            occ <= occ + CNT_W'(push) - CNT_W'(pop_fifo);
        end
    end

    // Payload storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept) begin
                tag_q[tag_wr] <= fetch_pc;
            end
            if (push) begin
                buf_q[buf_wr] <= {tag_q[tag_rd], imem_rsp_data};
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a directed vector table, hand
// sequences for redirect/wrap/latency corners, and randomized traffic checked
// against a program-order reference model driven by an in-order memory model.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_v;
    logic [31:0] imem_req_addr;
    logic        imem_req_rdy;
    logic        imem_rsp_v;
    logic [31:0] imem_rsp_data;
    logic        pc_v_x;
    logic [31:0] pc_x;
    logic        inst_rdy;
    logic        inst_v_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req_v   (imem_req_v),
        .imem_req_addr(imem_req_addr),
        .imem_req_rdy (imem_req_rdy),
        .imem_rsp_v   (imem_rsp_v),
        .imem_rsp_data(imem_rsp_data),
        .pc_v_x       (pc_v_x),
        .pc_x         (pc_x),
        .inst_rdy     (inst_rdy),
        .inst_v_i     (inst_v_i),
        .pc_i         (pc_i),
        .inst_i       (inst_i)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Memory model: in-order pending requests with their due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    lat = 1;          // 0 selects random latency 1..4 per request

    // Reference model: next expected request and next expected presented PC.
    logic [31:0] exp_req;
    logic [31:0] exp_pres;
    int          n_pop = 0;
    logic [31:0] acc_q[$];

    typedef struct {
        bit          rr;
        bit          rv;
        logic [31:0] ra;
        bit          rx;
        logic [31:0] px;
        bit          ir;
        bit          e_rv;
        logic [31:0] e_ad;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req_rdy  = 1'b0;
        imem_rsp_v    = 1'b0;
        imem_rsp_data = 32'h0;
        pc_v_x        = 1'b0;
        pc_x          = 32'h0;
        inst_rdy      = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk); #2;
        chk("reset_req_v",  32'(imem_req_v), 32'd0);
        chk("reset_addr",   imem_req_addr,   32'h0000_0000);
        chk("reset_inst_v", 32'(inst_v_i),   32'd0);
        chk("reset_pc_i",   pc_i,            32'h0);
        chk("reset_inst_i", inst_i,          32'h0);
        mq.delete();
        acc_q.delete();
        exp_req  = 32'h0;
        exp_pres = 32'h0;
        cyc      = 0;
    endtask

    // One cycle with the memory model answering requests.
    task automatic step(input bit rr, input bit ir, input bit rx, input logic [31:0] tgt);
        @(posedge clk); #1;
        reset        = 1'b0;
        imem_req_rdy = rr;
        inst_rdy     = ir;
        pc_v_x       = rx;
        pc_x         = tgt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_v    = 1'b1;
            imem_rsp_data = word_at(mq[0].addr);
        end else begin
            imem_rsp_v    = 1'b0;
            imem_rsp_data = $urandom();
        end
        #1;
        if (imem_rsp_v) void'(mq.pop_front());
        if (rx) begin
            chk("inst_v_in_redirect", 32'(inst_v_i),   32'd0);
            chk("req_v_in_redirect",  32'(imem_req_v), 32'd0);
            exp_req  = tgt & 32'hFFFF_FFFC;
            exp_pres = tgt & 32'hFFFF_FFFC;
        end else begin
            if (imem_req_v && imem_req_rdy) begin
                chk("req_addr", imem_req_addr, exp_req);
                mq.push_back('{imem_req_addr, cyc + ((lat == 0) ? int'($urandom_range(1, 4)) : lat)});
                acc_q.push_back(imem_req_addr);
                exp_req = exp_req + 32'd4;
                chk("outstanding_bound", 32'(mq.size() <= DEPTH), 32'd1);
            end
            if (inst_v_i && inst_rdy) begin
                chk("pc_i",   pc_i,   exp_pres);
                chk("inst_i", inst_i, word_at(exp_pres));
                exp_pres = exp_pres + 32'd4;
                n_pop++;
            end
        end
        cyc++;
    endtask

    function automatic vec_t mk(input bit rr, input bit rv, input logic [31:0] ra,
                                input bit rx, input logic [31:0] px, input bit ir,
                                input bit e_rv, input logic [31:0] e_ad,
                                input bit e_iv, input logic [31:0] e_pc);
        vec_t v;
        v = '{rr, rv, ra, rx, px, ir, e_rv, e_ad, e_iv, e_pc};
        return v;
    endfunction

    initial begin
        int k;
        int pops_before;
        reset = 1'b1;
        idle_inputs();

`ifndef FETCH_BYPASS_EN
        // Directed table from reset: 1-cycle memory, stall, req_rdy low, redirect.
        //             rr rv ra         rx px          ir | rv addr         iv pc
        tbl.push_back(mk(1, 0, 32'h00, 0, 32'h0,   1,   1, 32'h00,  0, 32'h00));
        tbl.push_back(mk(1, 1, 32'h00, 0, 32'h0,   1,   1, 32'h04,  0, 32'h00));
        tbl.push_back(mk(1, 1, 32'h04, 0, 32'h0,   1,   1, 32'h08,  1, 32'h00));
        tbl.push_back(mk(1, 1, 32'h08, 0, 32'h0,   1,   1, 32'h0C,  1, 32'h04));
        tbl.push_back(mk(1, 1, 32'h0C, 0, 32'h0,   0,   0, 32'h10,  1, 32'h08));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, 32'h0, 0, 32'h0, 0,  0, 32'h10,  1, 32'h08));
        tbl.push_back(mk(1, 0, 32'h00, 0, 32'h0,   1,   1, 32'h10,  1, 32'h08));
        tbl.push_back(mk(1, 1, 32'h10, 0, 32'h0,   1,   1, 32'h14,  1, 32'h0C));
        tbl.push_back(mk(1, 1, 32'h14, 0, 32'h0,   1,   1, 32'h18,  1, 32'h10));
        tbl.push_back(mk(0, 1, 32'h18, 0, 32'h0,   1,   1, 32'h1C,  1, 32'h14));
        tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   1,   1, 32'h1C,  1, 32'h18));
        tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   1,   1, 32'h1C,  0, 32'h00));
        tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   1,   1, 32'h1C,  0, 32'h00));
        tbl.push_back(mk(1, 0, 32'h00, 0, 32'h0,   1,   1, 32'h1C,  0, 32'h00));
        tbl.push_back(mk(1, 1, 32'h1C, 0, 32'h0,   1,   1, 32'h20,  0, 32'h00));
        tbl.push_back(mk(1, 1, 32'h20, 0, 32'h0,   1,   1, 32'h24,  1, 32'h1C));
        tbl.push_back(mk(1, 1, 32'h24, 1, 32'h102, 1,   0, 32'h28,  0, 32'h00));
        tbl.push_back(mk(1, 0, 32'h00, 0, 32'h0,   1,   1, 32'h100, 0, 32'h00));
        tbl.push_back(mk(1, 1, 32'h100,0, 32'h0,   1,   1, 32'h104, 0, 32'h00));
        tbl.push_back(mk(1, 1, 32'h104,0, 32'h0,   1,   1, 32'h108, 1, 32'h100));

        do_reset();
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            reset         = 1'b0;
            imem_req_rdy  = tbl[i].rr;
            imem_rsp_v    = tbl[i].rv;
            imem_rsp_data = word_at(tbl[i].ra);
            pc_v_x        = tbl[i].rx;
            pc_x          = tbl[i].px;
            inst_rdy      = tbl[i].ir;
            #1;
            chk($sformatf("tbl%0d_req_v", i),  32'(imem_req_v), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_addr", i),   imem_req_addr,   tbl[i].e_ad);
            chk($sformatf("tbl%0d_inst_v", i), 32'(inst_v_i),   32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_pc_i", i),   pc_i,   tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst_i", i), inst_i, word_at(tbl[i].e_pc));
            end
            cyc++;
        end
`endif

        // Response latency into an empty buffer.
        do_reset();
        lat = 1;
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("present_same_cycle", 32'(inst_v_i), 32'(BYP));
        step(1, 0, 0, 32'h0);
        chk("present_next_cycle", 32'(inst_v_i), 32'd1);
        chk("present_pc", pc_i, 32'h0);

        // Redirect with two outstanding requests on a 3-cycle memory.
        do_reset();
        lat = 3;
        k = 0;
        while (mq.size() < 2 && k < 20) begin
            step(1, 1, 0, 32'h0);
            k++;
        end
        chk("two_outstanding", 32'(mq.size()), 32'd2);
        step(1, 1, 1, 32'h0000_0102);
        step(1, 1, 0, 32'h0);
        chk("addr_after_redirect", imem_req_addr, 32'h0000_0100);
        pops_before = n_pop;
        k = 0;
        while (n_pop == pops_before && k < 30) begin
            step(1, 1, 0, 32'h0);
            k++;
        end
        chk("redirect_resumes", 32'(n_pop > pops_before), 32'd1);

        // PC wrap at the top of the address space.
        do_reset();
        lat = 1;
        step(1, 1, 1, 32'hFFFF_FFFE);
        acc_q.delete();
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0);
        chk("wrap_count_ok", 32'(acc_q.size() >= 2), 32'd1);
        if (acc_q.size() >= 2) begin
            chk("wrap_first", acc_q[0], 32'hFFFF_FFFC);
            chk("wrap_second", acc_q[1], 32'h0000_0000);
        end

        // Randomized traffic with variable latency, stalls and redirects,
        // including a reset in the middle.
        do_reset();
        lat = 0;
        pops_before = n_pop;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom());
        end
        chk("random_progress", 32'(n_pop - pops_before >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
